// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The arbiter uses the slave view; requesters and the memory use master.
interface mem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 11,
  parameter int DW   = 16
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic [OW-1:0]      owner;
  logic               busy;
  logic [AW-1:0]      mem_address;
  logic               mem_wr_en;
  logic [DW-1:0]      mem_data_in;
  logic [DW-1:0]      mem_data_out;

  modport master (
    output req, lock, we, addr, wdata, mem_data_out,
    input  ack, rdata, owner, busy,
    input  mem_address, mem_wr_en, mem_data_in
  );

  modport slave (
    input  req, lock, we, addr, wdata, mem_data_out,
    output ack, rdata, owner, busy,
    output mem_address, mem_wr_en, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with a bounded RMW lock in front of the
// single-port neighbor/cost memory (1-cycle registered read).
module mem_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 11,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic         clock,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [OW-1:0] own;
  logic [OW-1:0] rr;
  logic [OW-1:0] pick;
  logic [OW-1:0] win;
  logic [OW-1:0] rr_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_wr_en;
  logic          keep;
  logic          found;

  // first requester at or above the rr pointer, wrapping
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    keep  = bus.lock[own] & bus.req[own]
          & (cnt < CW'(LOCK_MAX));
    win   = keep ? own : pick;
    cnt_n = keep ? cnt + CW'(1) : CW'(1);
    rr_n  = (win == OW'(NREQ - 1)) ? '0
          : win + OW'(1);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|bus.req) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state       <= IDLE;
      own         <= '0;
      rr          <= '0;
      cnt         <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_wr_en   <= 1'b0;
    end else begin
      state     <= state_n;
      mem_wr_en <= 1'b0;
      if (state == IDLE && |bus.req) begin
        own         <= win;
        cnt         <= cnt_n;
        rr          <= rr_n;
        mem_address <= bus.addr[int'(win)*AW +: AW];
        mem_data_in <= bus.wdata[int'(win)*DW +: DW];
        mem_wr_en   <= bus.we[win];
      end
    end
  end

  always_comb begin
    bus.ack = '0;
    if (state == RESP) bus.ack[own] = 1'b1;
  end

  assign bus.rdata       = bus.mem_data_out;
  assign bus.owner       = own;
  assign bus.busy        = (state != IDLE);
  assign bus.mem_address = mem_address;
  assign bus.mem_wr_en   = mem_wr_en;
  assign bus.mem_data_in = mem_data_in;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of arbitrations plus
// hand sequences for reset, all-request ordering and abort.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic rst   = 1'b1;

  mem_arbiter_if #(.NREQ(4), .AW(11), .DW(16)) bus ();

  mem_arbiter #(
    .NREQ(4), .AW(11), .DW(16), .LOCK_MAX(4)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:2047];

  always @(posedge clock) begin
    if (bus.mem_wr_en) mem[bus.mem_address] <= bus.mem_data_in;
    bus.mem_data_out <= mem[bus.mem_address];
  end

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  we;
    logic [43:0] addr;
    logic [63:0] wdata;
    logic [3:0]  exp_ack;
    logic        chk_rd;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [3:0]  r, l, w,
    input logic [10:0] a0, a1, a2, a3,
    input logic [15:0] d0, d1,
    input logic [3:0]  ea,
    input logic        c,
    input logic [15:0] er
  );
    vec_t v;
    v.req     = r;
    v.lock    = l;
    v.we      = w;
    v.addr    = {a3, a2, a1, a0};
    v.wdata   = {16'h0, 16'h0, d1, d0};
    v.exp_ack = ea;
    v.chk_rd  = c;
    v.exp_rd  = er;
    return v;
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  vec_t        v;
  int          w;
  int          lat;
  int          wrs;
  logic [3:0]  got;
  logic [15:0] rd;
  logic [1:0]  ow;
  logic [10:0] acc_addr;
  logic [15:0] acc_data;
  logic [15:0] exp_t2 [4];

  initial begin
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;

    // write/read, edge addresses, lock, rotation, alternation
    tbl.push_back(mk(4'h1, 4'h0, 4'h1, 11'h01F, 11'h0, 11'h0, 11'h0, 16'h000A, 16'h0, 4'h1, 1'b0, 16'h0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 11'h01F, 11'h0, 11'h0, 11'h0, 16'h0, 16'h0, 4'h1, 1'b1, 16'h000A));
    tbl.push_back(mk(4'h1, 4'h0, 4'h1, 11'h000, 11'h0, 11'h0, 11'h0, 16'h1234, 16'h0, 4'h1, 1'b0, 16'h0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h1, 11'h7FF, 11'h0, 11'h0, 11'h0, 16'hBEEF, 16'h0, 4'h1, 1'b0, 16'h0));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 11'h7FF, 11'h0, 11'h0, 11'h0, 16'h0, 16'h0, 4'h1, 1'b1, 16'hBEEF));
    tbl.push_back(mk(4'h1, 4'h0, 4'h0, 11'h000, 11'h0, 11'h0, 11'h0, 16'h0, 16'h0, 4'h1, 1'b1, 16'h1234));
    tbl.push_back(mk(4'h2, 4'h0, 4'h2, 11'h0, 11'h100, 11'h0, 11'h0, 16'h0, 16'h0005, 4'h2, 1'b0, 16'h0));
    tbl.push_back(mk(4'hA, 4'h2, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h2, 1'b1, 16'h0005));
    tbl.push_back(mk(4'hA, 4'h2, 4'h2, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0006, 4'h2, 1'b0, 16'h0));
    tbl.push_back(mk(4'h8, 4'h0, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h8, 1'b0, 16'h0));
    tbl.push_back(mk(4'h2, 4'h2, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h2, 1'b1, 16'h0006));
    tbl.push_back(mk(4'hA, 4'h2, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h2, 1'b1, 16'h0006));
    tbl.push_back(mk(4'hA, 4'h2, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h2, 1'b1, 16'h0006));
    tbl.push_back(mk(4'hA, 4'h2, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h2, 1'b1, 16'h0006));
    tbl.push_back(mk(4'hA, 4'h2, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h8, 1'b0, 16'h0));
    tbl.push_back(mk(4'hA, 4'h2, 4'h0, 11'h0, 11'h100, 11'h0, 11'h200, 16'h0, 16'h0, 4'h2, 1'b1, 16'h0006));
    tbl.push_back(mk(4'h5, 4'h0, 4'h0, 11'h01F, 11'h0, 11'h7FF, 11'h0, 16'h0, 16'h0, 4'h4, 1'b1, 16'hBEEF));
    tbl.push_back(mk(4'h5, 4'h0, 4'h0, 11'h01F, 11'h0, 11'h7FF, 11'h0, 16'h0, 16'h0, 4'h1, 1'b1, 16'h000A));
    tbl.push_back(mk(4'h5, 4'h0, 4'h0, 11'h01F, 11'h0, 11'h7FF, 11'h0, 16'h0, 16'h0, 4'h4, 1'b1, 16'hBEEF));
    tbl.push_back(mk(4'h5, 4'h0, 4'h0, 11'h01F, 11'h0, 11'h7FF, 11'h0, 16'h0, 16'h0, 4'h1, 1'b1, 16'h000A));

    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    chk("rst ack", bus.ack, 4'h0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst owner", bus.owner, 2'd0);
    chk("rst mem_address", bus.mem_address, 11'h0);
    chk("rst mem_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst mem_data_in", bus.mem_data_in, 16'h0);
    @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      w = 0;
      for (int j = 0; j < 4; j++) if (v.exp_ack[j]) w = j;
      bus.req   = v.req;
      bus.lock  = v.lock;
      bus.we    = v.we;
      bus.addr  = v.addr;
      bus.wdata = v.wdata;
      lat = 0;
      wrs = 0;
      got = '0;
      rd  = '0;
      ow  = '0;
      acc_addr = '0;
      acc_data = '0;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clock);
        if (n == 2) begin
          acc_addr = bus.mem_address;
          acc_data = bus.mem_data_in;
        end
        if (bus.mem_wr_en) wrs++;
        if (bus.ack != 4'h0) begin
          lat = n;
          got = bus.ack;
          rd  = bus.rdata;
          ow  = bus.owner;
          break;
        end
      end
      chk($sformatf("v%0d ack", i), got, v.exp_ack);
      chk($sformatf("v%0d latency", i), lat, 3);
      chk($sformatf("v%0d owner", i), ow, w);
      chk($sformatf("v%0d mem_address", i), acc_addr, v.addr[w*11 +: 11]);
      chk($sformatf("v%0d wr cycles", i), wrs, v.we[w]);
      if (v.we[w])
        chk($sformatf("v%0d mem_data_in", i), acc_data, v.wdata[w*16 +: 16]);
      if (v.chk_rd)
        chk($sformatf("v%0d rdata", i), rd, v.exp_rd);
      @(posedge clock);
      #1;
    end

    // all four requesting right after reset: strict 0,1,2,3
    bus.req = '0;
    rst = 1'b1;
    @(posedge clock);
    #1 rst = 1'b0;
    exp_t2[0] = 16'h000A;
    exp_t2[1] = 16'h0006;
    exp_t2[2] = 16'hBEEF;
    exp_t2[3] = 16'h1234;
    bus.req  = 4'hF;
    bus.lock = 4'h0;
    bus.we   = 4'h0;
    bus.addr = {11'h000, 11'h7FF, 11'h100, 11'h01F};
    for (int k = 0; k < 4; k++) begin
      for (int n = 1; n <= 3; n++) begin
        @(negedge clock);
        chk($sformatf("all k%0d n%0d busy", k, n), bus.busy, n != 1);
        if (n == 3) begin
          chk($sformatf("all k%0d ack", k), bus.ack, 4'h1 << k);
          chk($sformatf("all k%0d rdata", k), bus.rdata, exp_t2[k]);
        end else begin
          chk($sformatf("all k%0d n%0d ack", k, n), bus.ack, 4'h0);
        end
      end
      @(posedge clock);
      #1 bus.req[k] = 1'b0;
    end

    // reset during the ACCESS cycle of a read aborts it silently
    bus.req  = 4'h1;
    bus.addr = {11'h000, 11'h7FF, 11'h100, 11'h01F};
    @(negedge clock);
    chk("abort n1 busy", bus.busy, 1'b0);
    @(negedge clock);
    chk("abort n2 busy", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clock);
    #1 rst = 1'b0;
    bus.req = 4'h4;
    @(negedge clock);
    chk("abort ack", bus.ack, 4'h0);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort owner", bus.owner, 2'd0);
    chk("abort mem_address", bus.mem_address, 11'h0);
    chk("abort mem_wr_en", bus.mem_wr_en, 1'b0);
    chk("abort mem_data_in", bus.mem_data_in, 16'h0);
    @(negedge clock);
    chk("after abort n2 ack", bus.ack, 4'h0);
    chk("after abort mem_address", bus.mem_address, 11'h7FF);
    @(negedge clock);
    chk("after abort ack", bus.ack, 4'h4);
    chk("after abort rdata", bus.rdata, 16'hBEEF);
    chk("after abort owner", bus.owner, 2'd2);
    @(posedge clock);
    #1 bus.req = 4'h0;
    @(negedge clock);
    chk("final idle ack", bus.ack, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
